// File: rtl/a78_loader.sv
// a78_loader: streams an Atari 7800 cart image into ROM, strips the 128-byte header and latches the mapper setup
module a78_loader #(
    parameter int ROM_AW = 18
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    input  logic              rom_ack,
    output logic [9:0]        cart_flags,
    output logic [31:0]       cart_size,
    output logic              header_valid,
    output logic              load_done,
    output logic              cart_reset,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    localparam logic [71:0] SIG = "ATARI7800";

    state_t            state, state_n;
    logic              dl_q, rise, fall;
    logic [31:0]       idx, addr_full, size_f;
    logic [1:0]        type_hi;
    logic [7:0]        type_lo;
    logic              hdr_match, sig_eq, in_gap, oob;
    logic              accept, drop, wr_go, issue, commit_go;
    logic              skid_full, skid_full_n, req_n;
    logic [ROM_AW-1:0] skid_addr;
    logic [7:0]        skid_data, sig_byte;
    logic [3:0]        sig_pos;

    assign load_done  = (state == COMMIT);
    assign cart_reset = (state != IDLE);

    // Download edge detector; starts high so a download already running at reset release is not a start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) dl_q <= 1'b1;
        else          dl_q <= ioctl_download;
    end

    // Load FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next state: a fresh download always restarts, otherwise drain the pipe then commit for one cycle
    always_comb begin
        state_n = state;
        case (state)
            LOAD:    state_n = fall ? DRAIN : LOAD;
            DRAIN:   state_n = (!skid_full && !rom_req) ? COMMIT : DRAIN;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rise) state_n = LOAD;
    end

    // Byte classification, ROM address mapping and skid/request handshake decisions
    always_comb begin
        rise        = ioctl_download & ~dl_q;
        fall        = ~ioctl_download & dl_q;
        sig_pos     = 4'd9 - idx[3:0];
        sig_byte    = 8'(SIG >> {sig_pos, 3'b000});
        sig_eq      = (ioctl_dout == sig_byte);
        in_gap      = header_valid && idx >= 32'd10 && idx < 32'd128;
        addr_full   = (header_valid && idx >= 32'd128) ? idx - 32'd128 : idx;
        oob         = |(addr_full >> ROM_AW);
        accept      = (state == LOAD) && ioctl_wr && !skid_full && !rise;
        drop        = (state == LOAD) && ioctl_wr && skid_full && !rise;
        wr_go       = accept && !in_gap && !oob;
        issue       = skid_full && !rom_req;
        skid_full_n = (skid_full && !issue) || wr_go;
        req_n       = issue || (rom_req && !rom_ack);
        commit_go   = (state == DRAIN) && (state_n == COMMIT);
    end

    // Byte intake: counter, header parse, skid register and the single outstanding ROM request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= 32'd0;
            header_valid <= 1'b0;
            overflow     <= 1'b0;
            hdr_match    <= 1'b0;
            size_f       <= 32'd0;
            type_hi      <= 2'd0;
            type_lo      <= 8'd0;
            skid_full    <= 1'b0;
            skid_addr    <= '0;
            skid_data    <= 8'd0;
            rom_req      <= 1'b0;
            rom_addr     <= '0;
            rom_data     <= 8'd0;
            ioctl_wait   <= 1'b0;
        end else if (rise) begin
            idx          <= 32'd0;
            header_valid <= 1'b0;
            overflow     <= 1'b0;
            hdr_match    <= 1'b1;
            size_f       <= 32'd0;
            type_hi      <= 2'd0;
            type_lo      <= 8'd0;
            skid_full    <= 1'b0;
            rom_req      <= 1'b0;
            ioctl_wait   <= 1'b0;
        end else begin
            skid_full  <= skid_full_n;
            rom_req    <= req_n;
            ioctl_wait <= skid_full_n || req_n;
            if (accept) begin
                idx <= idx + 32'd1;
                if (idx >= 32'd1 && idx <= 32'd9) hdr_match <= hdr_match & sig_eq;
                if (idx == 32'd9) header_valid <= hdr_match & sig_eq;
                if (idx >= 32'd49 && idx <= 32'd52) size_f <= {size_f[23:0], ioctl_dout};
                if (idx == 32'd53) type_hi <= ioctl_dout[1:0];
                if (idx == 32'd54) type_lo <= ioctl_dout;
            end
            if (wr_go) begin
                skid_addr <= addr_full[ROM_AW-1:0];
                skid_data <= ioctl_dout;
            end
            if (drop || (accept && !in_gap && oob)) overflow <= 1'b1;
            if (issue) begin
                rom_addr <= skid_addr;
                rom_data <= skid_data;
            end
        end
    end

    // Mapper configuration, loaded as a unit on entry to COMMIT so it is valid alongside load_done
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cart_flags <= 10'd0;
            cart_size  <= 32'd0;
        end else if (commit_go) begin
            cart_flags <= header_valid ? {type_hi[0], type_hi[1], type_lo} : 10'd0;
            cart_size  <= !header_valid ? idx :
                          (size_f != 32'd0) ? size_f :
                          (idx >= 32'd128) ? idx - 32'd128 : 32'd0;
        end
    end

endmodule
